dmem_responder: RTL and testbench

Handshaked data-memory responder serving the core's load/store requests. Replaces the zero-latency data memory behind the core's memory-access stage with a valid/ready request channel, a programmable wait-state counter, byte-lane store merging, load sign/zero extension, and an error response for misaligned, out-of-range or undefined accesses. The core is the initiator; this block is the responding end of that interface and owns the word-addressed storage array.

---
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request channel, programmable wait states,
// byte-lane store merging, load extension and error responses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    // state   | meaning
    // IDLE    | ready for a request
    // WAIT    | counting wait states; access happens on the exit edge
    // RESP    | response presented until resp_ready
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic [31:0] mem [DEPTH_WORDS];

    logic             acc_write;
    logic [2:0]       acc_funct3;
    logic [31:0]      acc_addr, acc_wdata;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err;
    logic [31:0]      word_rd, load_val, wr_data;
    logic [7:0]       byte_rd;
    logic [15:0]      half_rd;
    logic [3:0]       wr_be;
    logic             do_access;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the request fields are taken straight from the port in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_write  = req_write;
            acc_funct3 = req_funct3;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_write  = write_q;
            acc_funct3 = funct3_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
        end
    end

    assign acc_idx = acc_addr[IDX_W+1:2];

    always_comb begin
        acc_err = 1'b0;
        if (acc_addr[31:2] >= DEPTH_L) acc_err = 1'b1;
        if (acc_funct3[1:0] == 2'b01 && acc_addr[0]) acc_err = 1'b1;
        if (acc_funct3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00) acc_err = 1'b1;
        if (acc_write && acc_funct3 >= 3'b011) acc_err = 1'b1;
        if (!acc_write && (acc_funct3 == 3'b011 || acc_funct3 == 3'b110 || acc_funct3 == 3'b111))
            acc_err = 1'b1;
    end

    assign word_rd = mem[acc_idx];

    always_comb begin
        byte_rd  = word_rd[8*acc_addr[1:0] +: 8];
        half_rd  = acc_addr[1] ? word_rd[31:16] : word_rd[15:0];
        load_val = 32'h0;
        case (acc_funct3)
            3'b000:  load_val = {{24{byte_rd[7]}}, byte_rd};
            3'b001:  load_val = {{16{half_rd[15]}}, half_rd};
            3'b010:  load_val = word_rd;
            3'b100:  load_val = {24'h0, byte_rd};
            3'b101:  load_val = {16'h0, half_rd};
            default: load_val = 32'h0;
        endcase
    end

    always_comb begin
        wr_data = acc_wdata;
        wr_be   = 4'b1111;
        case (acc_funct3[1:0])
            2'b00: begin
                wr_data = {4{acc_wdata[7:0]}};
                wr_be   = 4'b0001 << acc_addr[1:0];
            end
            2'b01: begin
                wr_data = {2{acc_wdata[15:0]}};
                wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = acc_wdata;
                wr_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d   = ST_RESP;
                        do_access = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'h0;
                    error_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_access) begin
            error_d = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (state_q == ST_IDLE && req_valid) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    // Storage is deliberately outside the reset domain; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (reset && do_access && acc_write && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on the default build plus
// back-pressure, mid-WAIT reset and a zero-wait-state instance.
module tb_dmem_responder;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;

    logic        r0_valid = 1'b0, r0_write = 1'b0;
    logic [2:0]  r0_funct3 = 3'b000;
    logic [31:0] r0_addr = 32'h0, r0_wdata = 32'h0;
    logic        r0_ready, r0_resp_valid, r0_resp_error;
    logic [31:0] r0_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(r0_valid), .req_ready(r0_ready), .req_write(r0_write),
        .req_funct3(r0_funct3), .req_addr(r0_addr), .req_wdata(r0_wdata),
        .resp_valid(r0_resp_valid), .resp_ready(1'b1),
        .resp_rdata(r0_rdata), .resp_error(r0_resp_error)
    );

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        check("req_ready_before", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n = 1;
        while (!resp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(W + 1));
        rd = resp_rdata;
        er = resp_error;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec0_t;
    vec0_t v0[$];

    initial begin
        vt.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back('{1'b1, 3'b000, 32'h11,   32'h00000080, 32'h0,        1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD80EF, 1'b0});
        vt.push_back('{1'b0, 3'b000, 32'h11,   32'h0,        32'hFFFFFF80, 1'b0});
        vt.push_back('{1'b0, 3'b100, 32'h11,   32'h0,        32'h00000080, 1'b0});
        vt.push_back('{1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0});
        vt.push_back('{1'b0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h02,   32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b1, 3'b001, 32'h13,   32'h0000FFFF, 32'h0,        1'b1});
        vt.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b1, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b1, 3'b010, 32'h12,   32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD80EF, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h14,   32'h11223344, 32'h0,        1'b0});
        vt.push_back('{1'b1, 3'b001, 32'h16,   32'h1234ABCD, 32'h0,        1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h14,   32'h0,        32'hABCD3344, 1'b0});
        vt.push_back('{1'b0, 3'b100, 32'h15,   32'h0,        32'h00000033, 1'b0});
        vt.push_back('{1'b0, 3'b001, 32'h14,   32'h0,        32'h00003344, 1'b0});
        vt.push_back('{1'b0, 3'b000, 32'h17,   32'h0,        32'hFFFFFFAB, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h20,   32'h0,        32'h0,        1'b0});

        v0.push_back('{1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0});
        v0.push_back('{1'b1, 3'b010, 32'h4, 32'h0000807F, 32'h0});
        v0.push_back('{1'b0, 3'b010, 32'h0, 32'h0,        32'hCAFEF00D});
        v0.push_back('{1'b0, 3'b010, 32'h4, 32'h0,        32'h0000807F});
        v0.push_back('{1'b0, 3'b000, 32'h4, 32'h0,        32'h0000007F});
        v0.push_back('{1'b0, 3'b000, 32'h5, 32'h0,        32'hFFFFFF80});
        v0.push_back('{1'b0, 3'b101, 32'h2, 32'h0,        32'h0000CAFE});

        // Request offered during reset must be ignored.
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_error", {31'h0, resp_error}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'h0, resp_valid}, 32'h0);

        foreach (vt[i]) begin
            txn(vt[i].w, vt[i].f3, vt[i].a, vt[i].d, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_error", i), {31'h0, er}, {31'h0, vt[i].exp_err});
        end

        // Back-pressure: response must hold while resp_ready is low.
        begin
            int n;
            @(negedge clk);
            resp_ready = 1'b0;
            req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
            @(posedge clk);
            #1 req_valid = 1'b0;
            n = 0;
            @(negedge clk);
            while (!resp_valid && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("bp_resp_seen", {31'h0, resp_valid}, 32'h1);
            repeat (5) begin
                @(negedge clk);
                check("bp_valid", {31'h0, resp_valid}, 32'h1);
                check("bp_rdata", resp_rdata, 32'hDEAD80EF);
                check("bp_req_ready", {31'h0, req_ready}, 32'h0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            check("bp_release_ready", {31'h0, req_ready}, 32'h1);
            check("bp_release_valid", {31'h0, resp_valid}, 32'h0);
        end

        // Reset during WAIT discards the pending store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("midwait_busy", {31'h0, req_ready}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("midwait_rst_ready", {31'h0, req_ready}, 32'h1);
        check("midwait_rst_valid", {31'h0, resp_valid}, 32'h0);
        check("midwait_rst_rdata", resp_rdata, 32'h0);
        check("midwait_rst_error", {31'h0, resp_error}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        txn(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
        check("midwait_lw20", rd, 32'h0);
        check("midwait_lw20_err", {31'h0, er}, 32'h0);

        // Zero-wait-state build: back-to-back requests, one response per 2 cycles.
        @(negedge clk);
        foreach (v0[i]) begin
            check($sformatf("w0_ready%0d", i), {31'h0, r0_ready}, 32'h1);
            r0_valid = 1'b1; r0_write = v0[i].w; r0_funct3 = v0[i].f3;
            r0_addr = v0[i].a; r0_wdata = v0[i].d;
            @(negedge clk);
            check($sformatf("w0_valid%0d", i), {31'h0, r0_resp_valid}, 32'h1);
            check($sformatf("w0_rdata%0d", i), r0_rdata, v0[i].exp_rd);
            check($sformatf("w0_busy%0d", i), {31'h0, r0_ready}, 32'h0);
            @(negedge clk);
        end
        r0_valid = 1'b0;
        @(negedge clk);
        check("w0_idle", {31'h0, r0_resp_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
